rename_regfile: RTL
===================

Name: rename_regfile

Overview:
- Architectural register file plus per-register rename tag (ROB index) and busy bit.
- Sits beside the reorder buffer:
  - consumes its commit port (write_reg_id/write_val/write_ROB_id) and its new-tail port (new_reg_id/new_ROB_id);
  - answers decoder operand lookups, forwarding through the ROB's rs1/rs2 query ports when a source is still renamed.
- Flushes all rename state on branch-mispredict clear.

Parameters:
- ROB_WIDTH_BIT, 5, width of ROB index / rename tag (32-entry ROB).
- XLEN, 32, register data width.
- NREG, 32, number of architectural registers; x0 hardwired zero.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low freezes all state updates
- clear_in  in  1  ROB clear_flag; flush rename state
- cmt_reg_id  in  5  commit destination register (0 = no commit)
- cmt_val  in  XLEN  commit value
- cmt_rob_id  in  ROB_WIDTH_BIT  ROB index being committed
- ren_reg_id  in  5  newly dispatched rd (0 = none)
- ren_rob_id  in  ROB_WIDTH_BIT  ROB tail assigned to it
- dec_rs1  in  5  decoder source 1 register
- dec_rs2  in  5  decoder source 2 register
- rob_q1_id  out  ROB_WIDTH_BIT  tag of rs1, to ROB rs1_id
- rob_q1_ready  in  1  ROB rs1_ready
- rob_q1_val  in  XLEN  ROB rs1_val
- rob_q2_id  out  ROB_WIDTH_BIT  tag of rs2, to ROB rs2_id
- rob_q2_ready  in  1  ROB rs2_ready
- rob_q2_val  in  XLEN  ROB rs2_val
- op1_ready  out  1  source 1 value available
- op1_val  out  XLEN  source 1 value (valid when op1_ready)
- op1_tag  out  ROB_WIDTH_BIT  producer ROB index when !op1_ready
- op2_ready, op2_val, op2_tag  out  1/XLEN/ROB_WIDTH_BIT  same for source 2

Behaviour:
- State: val[NREG], tag[NREG], busy[NREG].
- Reset (rst_in low, async): all val=0, tag=0, busy=0. Outputs are combinational from state; after reset op*_ready=1, op*_val=0, op*_tag=0, rob_q*_id=0.
- All updates on posedge clk_in only when rdy_in=1; rdy_in=0 holds state, lookups stay combinational.
- Commit (cmt_reg_id≠0):
  - val[cmt_reg_id] <= cmt_val.
  - busy cleared only if tag[cmt_reg_id]==cmt_rob_id and the same register is not renamed this cycle.
- Rename (ren_reg_id≠0): tag <= ren_rob_id, busy <= 1.
- Same register committed and renamed in one cycle: value written, rename wins (busy=1, new tag).
- Commit whose tag is stale (register re-renamed): value still written, busy unchanged.
- clear_in=1 && rdy_in=1: all busy <= 0, tags <= 0. Values are kept, but the same-cycle commit value is still written and the same-cycle rename is ignored.
- x0 never written, never busy; lookups of x0 return ready=1, val=0.
- Lookup (per source, combinational, priority order):
  1. !busy[rs] → ready=1, val=val[rs].
  2. busy and commit this cycle to rs with matching tag → ready=1, val=cmt_val (bypass).
  3. busy → rob_q_id=tag[rs]; ready=rob_q_ready, val=rob_q_val, tag=tag[rs].
- rob_q*_id always drives tag[rs] (0 for non-busy).
- Lookup sees pre-edge state. A rename issued in the same cycle does not affect the same-cycle lookup; the decoder orders rs reads before its own rd rename.
- Writes are visible to lookups the cycle after the edge.

Optional Feature:
- Macro: REGFILE_CMT_BYPASS_EN.
- Defined: lookup step 2 active (same-cycle commit forwarded).
- Undefined: step 2 removed; a busy source under commit is resolved via the ROB query path (the ROB entry is still ready in its commit cycle), so results are identical. This removes one 32-bit mux per source for timing.

Decomposition:
- Shared package/const.v: ROB_WIDTH_BIT, XLEN, NREG, REG_ZERO index.
- One sub-module, regfile_lookup: the combinational per-source priority mux, instantiated twice.
- The top holds storage and update logic.

Test Plan:
- Reset mid-run: rename x5→tag 3, then drop rst_in asynchronously → busy[5]=0 immediately; op1 lookup x5 gives ready=1, val=0.
- Rename x5→tag 7, next cycle dec_rs1=5 with rob_q1_ready=0 → op1_ready=0, op1_tag=7, rob_q1_id=7. Then rob_q1_ready=1, rob_q1_val=0xAB → op1_ready=1, op1_val=0xAB.
- Rename x5→tag 7, rename x5→tag 9, then commit (x5, 0x11, tag 7) → val[5]=0x11, busy stays 1, op1_tag=9.
- Same cycle commit (x6, 0x22, tag 4 matching) and rename x6→tag 12 → next cycle busy[6]=1, tag=12, val=0x22.
- With bypass: busy x8 tag 2, commit (x8, 0x33, tag 2), dec_rs2=8 same cycle → op2_ready=1, op2_val=0x33 regardless of rob_q2_ready.
- clear_in with x1..x4 busy plus rename x10 → next cycle all ready with retained values, x10 not busy. Writes to x0 and rdy_in=0 cycles leave state unchanged.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared sizing constants and types for the rename
// register file slice.
//   DEF_ROB_WIDTH_BIT - default rename tag width (32-entry ROB)
//   DEF_XLEN          - default register data width
//   DEF_NREG          - default architectural register count
//   REG_ID_W          - architectural register index width
//   REG_ZERO          - index of the hardwired-zero register x0
package rename_regfile_pkg;

  localparam int unsigned DEF_ROB_WIDTH_BIT = 5;
  localparam int unsigned DEF_XLEN          = 32;
  localparam int unsigned DEF_NREG          = 32;
  localparam int unsigned REG_ID_W          = 5;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  localparam reg_id_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_lookup.sv
// regfile_lookup: combinational operand resolution for one decoder source.
// Priority: not busy -> register value; (with REGFILE_CMT_BYPASS_EN) busy
// and committing this cycle with a matching tag -> commit value; otherwise
// forward whatever the ROB query port returns for the register's tag.
// Ports:
//   busy, reg_val, reg_tag       - state of the looked-up register
//   cmt_hit, cmt_val             - same-cycle matching commit (macro only)
//   rob_q_ready, rob_q_val       - ROB answer for rob_q_id
//   rob_q_id                     - tag sent to the ROB (0 when not busy)
//   op_ready, op_val, op_tag     - resolved operand
module regfile_lookup #(
  parameter int unsigned ROB_WIDTH_BIT = 5,
  parameter int unsigned XLEN          = 32
) (
  input  logic                     busy,
  input  logic [XLEN-1:0]          reg_val,
  input  logic [ROB_WIDTH_BIT-1:0] reg_tag,
`ifdef REGFILE_CMT_BYPASS_EN
  input  logic                     cmt_hit,
  input  logic [XLEN-1:0]          cmt_val,
`endif
  input  logic                     rob_q_ready,
  input  logic [XLEN-1:0]          rob_q_val,
  output logic [ROB_WIDTH_BIT-1:0] rob_q_id,
  output logic                     op_ready,
  output logic [XLEN-1:0]          op_val,
  output logic [ROB_WIDTH_BIT-1:0] op_tag
);

  // A committed register keeps its last tag; mask it so idle lookups
  // present tag 0 to the ROB and the decoder.
  assign rob_q_id = busy ? reg_tag : '0;
  assign op_tag   = busy ? reg_tag : '0;

  always_comb begin
    op_ready = 1'b1;
    op_val   = reg_val;
    if (busy) begin
`ifdef REGFILE_CMT_BYPASS_EN
      if (cmt_hit) begin
        op_ready = 1'b1;
        op_val   = cmt_val;
      end else begin
        op_ready = rob_q_ready;
        op_val   = rob_q_val;
      end
`else
      op_ready = rob_q_ready;
      op_val   = rob_q_val;
`endif
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename tag
// and busy bit, sitting beside the reorder buffer.
// Optional macro REGFILE_CMT_BYPASS_EN forwards a same-cycle matching commit
// directly instead of through the ROB query port.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (freeze), clear_in (flush)
//   cmt_reg_id/cmt_val/cmt_rob_id  - ROB commit port (reg 0 = none)
//   ren_reg_id/ren_rob_id          - newly dispatched rd and its ROB tail
//   dec_rs1/dec_rs2                - decoder source registers
//   rob_q1_*/rob_q2_*              - ROB rs1/rs2 query ports
//   op1_*/op2_*                    - resolved operands to the decoder
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int unsigned ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
  parameter int unsigned XLEN          = DEF_XLEN,
  parameter int unsigned NREG          = DEF_NREG
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic [REG_ID_W-1:0]      cmt_reg_id,
  input  logic [XLEN-1:0]          cmt_val,
  input  logic [ROB_WIDTH_BIT-1:0] cmt_rob_id,
  input  logic [REG_ID_W-1:0]      ren_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] ren_rob_id,
  input  logic [REG_ID_W-1:0]      dec_rs1,
  input  logic [REG_ID_W-1:0]      dec_rs2,
  output logic [ROB_WIDTH_BIT-1:0] rob_q1_id,
  input  logic                     rob_q1_ready,
  input  logic [XLEN-1:0]          rob_q1_val,
  output logic [ROB_WIDTH_BIT-1:0] rob_q2_id,
  input  logic                     rob_q2_ready,
  input  logic [XLEN-1:0]          rob_q2_val,
  output logic                     op1_ready,
  output logic [XLEN-1:0]          op1_val,
  output logic [ROB_WIDTH_BIT-1:0] op1_tag,
  output logic                     op2_ready,
  output logic [XLEN-1:0]          op2_val,
  output logic [ROB_WIDTH_BIT-1:0] op2_tag
);

  logic [XLEN-1:0]          val_q [NREG];
  logic [ROB_WIDTH_BIT-1:0] tag_q [NREG];
  logic [NREG-1:0]          busy_q;

  logic cmt_en;
  logic ren_en;

  assign cmt_en = (cmt_reg_id != REG_ZERO);
  assign ren_en = (ren_reg_id != REG_ZERO);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      if (cmt_en)
        val_q[cmt_reg_id] <= cmt_val;
      if (clear_in) begin
        for (int unsigned i = 0; i < NREG; i++)
          tag_q[i] <= '0;
        busy_q <= '0;
      end else begin
        // A stale commit (register re-renamed since) leaves busy alone.
        if (cmt_en && (tag_q[cmt_reg_id] == cmt_rob_id) && (cmt_reg_id != ren_reg_id))
          busy_q[cmt_reg_id] <= 1'b0;
        if (ren_en) begin
          tag_q[ren_reg_id]  <= ren_rob_id;
          busy_q[ren_reg_id] <= 1'b1;
        end
      end
    end
  end

`ifdef REGFILE_CMT_BYPASS_EN
  logic cmt_hit1;
  logic cmt_hit2;

  assign cmt_hit1 = cmt_en && (cmt_reg_id == dec_rs1) && (tag_q[dec_rs1] == cmt_rob_id);
  assign cmt_hit2 = cmt_en && (cmt_reg_id == dec_rs2) && (tag_q[dec_rs2] == cmt_rob_id);
`endif

  regfile_lookup #(
    .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
    .XLEN          (XLEN)
  ) u_lookup1 (
    .busy        (busy_q[dec_rs1]),
    .reg_val     (val_q[dec_rs1]),
    .reg_tag     (tag_q[dec_rs1]),
`ifdef REGFILE_CMT_BYPASS_EN
    .cmt_hit     (cmt_hit1),
    .cmt_val     (cmt_val),
`endif
    .rob_q_ready (rob_q1_ready),
    .rob_q_val   (rob_q1_val),
    .rob_q_id    (rob_q1_id),
    .op_ready    (op1_ready),
    .op_val      (op1_val),
    .op_tag      (op1_tag)
  );

  regfile_lookup #(
    .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
    .XLEN          (XLEN)
  ) u_lookup2 (
    .busy        (busy_q[dec_rs2]),
    .reg_val     (val_q[dec_rs2]),
    .reg_tag     (tag_q[dec_rs2]),
`ifdef REGFILE_CMT_BYPASS_EN
    .cmt_hit     (cmt_hit2),
    .cmt_val     (cmt_val),
`endif
    .rob_q_ready (rob_q2_ready),
    .rob_q_val   (rob_q2_val),
    .rob_q_id    (rob_q2_id),
    .op_ready    (op2_ready),
    .op_val      (op2_val),
    .op_tag      (op2_tag)
  );

endmodule
